alu_ctrl_datapath: RTL and testbench
====================================

ALU_CTRL_DATAPATH -- requirements
Module: alu_ctrl_datapath

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, datapath width.
REQ-003 SHALL have clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have opr  input  4  current opcode.
REQ-006 SHALL have halt  input  1  1 = second (execute) byte of a two-byte instruction.
REQ-007 SHALL have a  input  8  register-file read port 1 (ALU operand A).
REQ-008 SHALL have rd2  input  8  register-file read port 2.
REQ-009 SHALL have cin  input  1  stored carry flag.
REQ-010 SHALL have addr  input  13  data-memory address.
REQ-011 SHALL have sel  output  6  control word: [0] ra1 from di, [1] operand B from memory, [2] register write, [3] memory write, [4] jump enable, [5] wa from di.
REQ-012 SHALL have alu_cont  output  3  ALU operation code.
REQ-013 SHALL have y  output  8  ALU result.
REQ-014 SHALL have cout  output  1  ALU carry/borrow.
REQ-015 SHALL have zero  output  1  1 when y == 0.
REQ-016 SHALL have dout  output  8  memory read data at addr.
REQ-017 SHALL have flag_we  output  1  1 when the C/Z/N flags are to be captured.

Function
REQ-018 Operand B SHALL be dout when sel[1]=1, else rd2; the selection is combinational.
REQ-019 The ALU SHALL be combinational with these ops: 000 y=B; 001 {cout,y}=A+B; 010 y=A-B with cout=1 iff A<B unsigned; 011 y=A&B; 100 y=~A; 101 y=A; 110 {cout,y}=A+B+cin; 111 y=0. cout SHALL be 0 for every op that does not specify it.
REQ-020 zero SHALL equal (y==0) for every op.
REQ-021 The decode SHALL be combinational from (halt, opr), giving alu_cont / sel / flag_we as follows when halt=1:
- 0000 LDA: 000 / 100111 / 1
- 0001 STA: 101 / 001001 / 0
- 0010 ADDM: 001 / 100111 / 1
- 0011 SUBM: 010 / 100111 / 1
- 0110 JMP: 101 / 010000 / 0
REQ-022 The decode SHALL give alu_cont / sel / flag_we as follows when halt=0:
- 1000 MOV: 101 / 000100 / 0
- 1001 ADD: 001 / 000100 / 1
- 1010 SUB: 010 / 000100 / 1
- 1011 AND: 011 / 000100 / 1
REQ-023 Every other (halt, opr) combination, including 111x config and all first-byte phases, SHALL output alu_cont=000, sel=000000 and flag_we=0.
REQ-024 The data memory SHALL be 2^ADDR_W x 8; dout SHALL be an asynchronous read of mem[addr].
REQ-025 When sel[3]=1, mem[addr] SHALL be written with y at the rising clk edge; the new value SHALL appear on dout after that edge.
REQ-026 Addresses SHALL be fully decoded with no aliasing; 0x1FFF and 0x0000 are distinct locations.
REQ-027 A simultaneous read and write to the same address SHALL return the old data before the edge and the new data after it.

Reset
REQ-028 While rst=1, sel, alu_cont and flag_we SHALL be forced to 0, and no memory write SHALL occur on that edge.
REQ-029 Memory contents SHALL NOT be cleared by reset; the block holds no other state.

Structure
REQ-030 A shared package SHALL hold the ALU op constants (3-bit), the opcode constants (4-bit) and the sel bit-index constants.
REQ-031 The memory SHALL be a single sub-module, datamem_8k; the ALU, B mux and decoder SHALL be in the top module.

Verification
REQ-032 Check halt=0, opr=1001, a=0xF0, rd2=0x20 -> y=0x10, cout=1, zero=0, sel=000100, flag_we=1.
REQ-033 Check halt=0, opr=1010, a=0x05, rd2=0x05 -> y=0x00, zero=1, cout=0; then a=0x03, rd2=0x05 -> y=0xFE, cout=1.
REQ-034 Check halt=1, opr=0001, addr=0x1ABC, a=0x5A, one edge -> dout=0x5A; then halt=1, opr=0000 -> y=0x5A, sel=100111, flag_we=1.
REQ-035 Check rst=1 with halt=1, opr=0001, a=0xFF at a previously written address -> contents unchanged and sel=000000.
REQ-036 Check halt=1, opr=0110 -> sel=010000, flag_we=0; halt=0, opr=0110 -> sel=000000.
REQ-037 Check write 0x11 at 0x1FFF, then 0x22 at 0x0000 -> reads return 0x11 and 0x22 respectively.

Source files
------------

// File: rtl/alu_ctrl_datapath_pkg.sv
// ALU/control datapath shared definitions:
// ALU op codes, opcodes and control-word bit indices.
package alu_ctrl_datapath_pkg;

  localparam logic [2:0] ALU_PASSB = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_NOTA  = 3'b100;
  localparam logic [2:0] ALU_PASSA = 3'b101;
  localparam logic [2:0] ALU_ADC   = 3'b110;
  localparam logic [2:0] ALU_ZERO  = 3'b111;

  localparam logic [3:0] OP_LDA  = 4'b0000;
  localparam logic [3:0] OP_STA  = 4'b0001;
  localparam logic [3:0] OP_ADDM = 4'b0010;
  localparam logic [3:0] OP_SUBM = 4'b0011;
  localparam logic [3:0] OP_JMP  = 4'b0110;
  localparam logic [3:0] OP_MOV  = 4'b1000;
  localparam logic [3:0] OP_ADD  = 4'b1001;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_AND  = 4'b1011;

  localparam int SEL_RA1_DI = 0;
  localparam int SEL_B_MEM  = 1;
  localparam int SEL_REG_WE = 2;
  localparam int SEL_MEM_WE = 3;
  localparam int SEL_JMP    = 4;
  localparam int SEL_WA_DI  = 5;

endpackage

// File: rtl/alu_ctrl_datapath_if.sv
// ALU/control datapath bus:
// decode inputs, operands, and results.
interface alu_ctrl_datapath_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic [3:0]        opr;
  logic              halt;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] rd2;
  logic              cin;
  logic [ADDR_W-1:0] addr;
  logic [5:0]        sel;
  logic [2:0]        alu_cont;
  logic [DATA_W-1:0] y;
  logic              cout;
  logic              zero;
  logic [DATA_W-1:0] dout;
  logic              flag_we;

  modport master (
    output opr, halt, a, rd2,
    output cin, addr,
    input  sel, alu_cont, y,
    input  cout, zero, dout,
    input  flag_we
  );

  modport slave (
    input  opr, halt, a, rd2,
    input  cin, addr,
    output sel, alu_cont, y,
    output cout, zero, dout,
    output flag_we
  );
endinterface

// File: rtl/datamem_8k.sv
// Data memory: async read, sync write,
// no reset so contents survive rst.
module datamem_8k #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // write port: capture din on the rising edge
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/alu_ctrl_datapath.sv
// ALU, operand-B mux and instruction decode
// around the data memory.
module alu_ctrl_datapath
  import alu_ctrl_datapath_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic rst,
  alu_ctrl_datapath_if.slave bus
);

  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] y;
  logic [DATA_W:0]   sum;
  logic              cout;
  logic [5:0]        sel;
  logic [2:0]        alu_cont;
  logic              flag_we;
  logic [DATA_W-1:0] dout;

  assign b = sel[SEL_B_MEM] ? dout : bus.rd2;

  // ALU: pure combinational, cout only where the op defines it
  always_comb begin
    y    = '0;
    cout = 1'b0;
    sum  = '0;
    case (alu_cont)
      ALU_PASSB: y = b;
      ALU_ADD: begin
        sum  = {1'b0, bus.a} + {1'b0, b};
        y    = sum[DATA_W-1:0];
        cout = sum[DATA_W];
      end
      ALU_SUB: begin
        y    = bus.a - b;
        cout = (bus.a < b);
      end
      ALU_AND:   y = bus.a & b;
      ALU_NOTA:  y = ~bus.a;
      ALU_PASSA: y = bus.a;
      ALU_ADC: begin
        sum  = {1'b0, bus.a} + {1'b0, b}
             + {{DATA_W{1'b0}}, bus.cin};
        y    = sum[DATA_W-1:0];
        cout = sum[DATA_W];
      end
      ALU_ZERO:  y = '0;
    endcase
  end

  // decode from (halt, opr); reset masks every control output
  always_comb begin
    sel      = '0;
    alu_cont = ALU_PASSB;
    flag_we  = 1'b0;
    case ({bus.halt, bus.opr})
      {1'b1, OP_LDA}: begin
        alu_cont        = ALU_PASSB;
        sel[SEL_WA_DI]  = 1'b1;
        sel[SEL_REG_WE] = 1'b1;
        sel[SEL_B_MEM]  = 1'b1;
        sel[SEL_RA1_DI] = 1'b1;
        flag_we         = 1'b1;
      end
      {1'b1, OP_STA}: begin
        alu_cont        = ALU_PASSA;
        sel[SEL_MEM_WE] = 1'b1;
        sel[SEL_RA1_DI] = 1'b1;
      end
      {1'b1, OP_ADDM}: begin
        alu_cont        = ALU_ADD;
        sel[SEL_WA_DI]  = 1'b1;
        sel[SEL_REG_WE] = 1'b1;
        sel[SEL_B_MEM]  = 1'b1;
        sel[SEL_RA1_DI] = 1'b1;
        flag_we         = 1'b1;
      end
      {1'b1, OP_SUBM}: begin
        alu_cont        = ALU_SUB;
        sel[SEL_WA_DI]  = 1'b1;
        sel[SEL_REG_WE] = 1'b1;
        sel[SEL_B_MEM]  = 1'b1;
        sel[SEL_RA1_DI] = 1'b1;
        flag_we         = 1'b1;
      end
      {1'b1, OP_JMP}: begin
        alu_cont     = ALU_PASSA;
        sel[SEL_JMP] = 1'b1;
      end
      {1'b0, OP_MOV}: begin
        alu_cont        = ALU_PASSA;
        sel[SEL_REG_WE] = 1'b1;
      end
      {1'b0, OP_ADD}: begin
        alu_cont        = ALU_ADD;
        sel[SEL_REG_WE] = 1'b1;
        flag_we         = 1'b1;
      end
      {1'b0, OP_SUB}: begin
        alu_cont        = ALU_SUB;
        sel[SEL_REG_WE] = 1'b1;
        flag_we         = 1'b1;
      end
      {1'b0, OP_AND}: begin
        alu_cont        = ALU_AND;
        sel[SEL_REG_WE] = 1'b1;
        flag_we         = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      sel      = '0;
      alu_cont = ALU_PASSB;
      flag_we  = 1'b0;
    end
  end

  datamem_8k #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (sel[SEL_MEM_WE]),
    .addr (bus.addr),
    .din  (y),
    .dout (dout)
  );

  assign bus.sel      = sel;
  assign bus.alu_cont = alu_cont;
  assign bus.flag_we  = flag_we;
  assign bus.y        = y;
  assign bus.cout     = cout;
  assign bus.zero     = (y == '0);
  assign bus.dout     = dout;

endmodule

// File: tb/tb_alu_ctrl_datapath.sv
// Directed bench for alu_ctrl_datapath
// with an expected-result scoreboard.
module tb_alu_ctrl_datapath;

  logic clk;
  logic rst;

  alu_ctrl_datapath_if #(
    .ADDR_W (13),
    .DATA_W (8)
  ) bus ();

  alu_ctrl_datapath #(
    .ADDR_W (13),
    .DATA_W (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] M_Y  = 7'h01;
  localparam logic [6:0] M_C  = 7'h02;
  localparam logic [6:0] M_Z  = 7'h04;
  localparam logic [6:0] M_S  = 7'h08;
  localparam logic [6:0] M_A  = 7'h10;
  localparam logic [6:0] M_F  = 7'h20;
  localparam logic [6:0] M_D  = 7'h40;
  localparam logic [6:0] M_CT = 7'h38;

  typedef struct {
    string      tag;
    logic [6:0] mask;
    logic [7:0] y;
    logic       cout;
    logic       zero;
    logic [5:0] sel;
    logic [2:0] alu;
    logic       fwe;
    logic [7:0] dout;
  } exp_t;

  exp_t sb[$];
  int compared;
  int mismatched;

  task automatic cmp(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r,
                       input logic h,
                       input logic [3:0] o,
                       input logic [7:0] av,
                       input logic [7:0] bv,
                       input logic [12:0] ad);
    @(negedge clk);
    rst      = r;
    bus.halt = h;
    bus.opr  = o;
    bus.a    = av;
    bus.rd2  = bv;
    bus.addr = ad;
  endtask

  task automatic push(input string tag,
                      input logic [6:0] m,
                      input logic [7:0] yv,
                      input logic cv,
                      input logic zv,
                      input logic [5:0] sv,
                      input logic [2:0] alv,
                      input logic fv,
                      input logic [7:0] dv);
    exp_t e;
    e.tag  = tag;
    e.mask = m;
    e.y    = yv;
    e.cout = cv;
    e.zero = zv;
    e.sel  = sv;
    e.alu  = alv;
    e.fwe  = fv;
    e.dout = dv;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL sb_empty observed=0 expected>0");
      return;
    end
    e = sb.pop_front();
    if (e.mask[0])
      cmp({e.tag, ".y"}, bus.y, e.y);
    if (e.mask[1])
      cmp({e.tag, ".cout"}, {7'd0, bus.cout},
          {7'd0, e.cout});
    if (e.mask[2])
      cmp({e.tag, ".zero"}, {7'd0, bus.zero},
          {7'd0, e.zero});
    if (e.mask[3])
      cmp({e.tag, ".sel"}, {2'd0, bus.sel},
          {2'd0, e.sel});
    if (e.mask[4])
      cmp({e.tag, ".alu"}, {5'd0, bus.alu_cont},
          {5'd0, e.alu});
    if (e.mask[5])
      cmp({e.tag, ".fwe"}, {7'd0, bus.flag_we},
          {7'd0, e.fwe});
    if (e.mask[6])
      cmp({e.tag, ".dout"}, bus.dout, e.dout);
  endtask

  task automatic after_edge(input string tag,
                            input logic [7:0] dv);
    @(posedge clk);
    push(tag, M_D, 8'h00, 1'b0, 1'b0,
         6'b0, 3'b0, 1'b0, dv);
    check_front();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst      = 1'b1;
    bus.halt = 1'b1;
    bus.opr  = 4'b0000;
    bus.a    = 8'h00;
    bus.rd2  = 8'h00;
    bus.cin  = 1'b0;
    bus.addr = 13'h0000;

    drive(1, 1, 4'b0000, 8'h00, 8'h00, 13'h0);
    push("reset", M_CT | M_A, 0, 0, 0,
         6'b000000, 3'b000, 0, 0);
    check_front();

    drive(0, 0, 4'b1001, 8'hF0, 8'h20, 13'h0);
    push("add", 7'h3F, 8'h10, 1, 0,
         6'b000100, 3'b001, 1, 0);
    check_front();

    drive(0, 0, 4'b1010, 8'h05, 8'h05, 13'h0);
    push("sub_eq", 7'h3F, 8'h00, 0, 1,
         6'b000100, 3'b010, 1, 0);
    check_front();

    drive(0, 0, 4'b1010, 8'h03, 8'h05, 13'h0);
    push("sub_brw", M_Y | M_C | M_Z, 8'hFE,
         1, 0, 0, 0, 0, 0);
    check_front();

    drive(0, 0, 4'b1011, 8'hCC, 8'hAA, 13'h0);
    push("and", 7'h3F, 8'h88, 0, 0,
         6'b000100, 3'b011, 1, 0);
    check_front();

    drive(0, 0, 4'b1000, 8'h3C, 8'h99, 13'h0);
    push("mov", 7'h3F, 8'h3C, 0, 0,
         6'b000100, 3'b101, 0, 0);
    check_front();

    drive(0, 1, 4'b0001, 8'h5A, 8'h00, 13'h1ABC);
    push("sta", 7'h3F, 8'h5A, 0, 0,
         6'b001001, 3'b101, 0, 0);
    check_front();
    after_edge("sta_wr", 8'h5A);

    drive(0, 1, 4'b0000, 8'h00, 8'h00, 13'h1ABC);
    push("lda", 7'h7F, 8'h5A, 0, 0,
         6'b100111, 3'b000, 1, 8'h5A);
    check_front();

    drive(0, 1, 4'b0010, 8'h10, 8'hFF, 13'h1ABC);
    push("addm", 7'h3F, 8'h6A, 0, 0,
         6'b100111, 3'b001, 1, 0);
    check_front();

    drive(0, 1, 4'b0011, 8'h50, 8'h00, 13'h1ABC);
    push("subm", 7'h3F, 8'hF6, 1, 0,
         6'b100111, 3'b010, 1, 0);
    check_front();

    drive(0, 1, 4'b0001, 8'h77, 8'h00, 13'h1ABC);
    push("rw_old", M_D | M_S, 0, 0, 0,
         6'b001001, 0, 0, 8'h5A);
    check_front();
    after_edge("rw_new", 8'h77);

    drive(1, 1, 4'b0001, 8'hFF, 8'h00, 13'h1ABC);
    push("rst_sta", M_CT | M_A, 0, 0, 0,
         6'b000000, 3'b000, 0, 0);
    check_front();
    drive(0, 0, 4'b1111, 8'h00, 8'h00, 13'h1ABC);
    push("rst_nowr", M_D | M_CT, 0, 0, 0,
         6'b000000, 0, 0, 8'h77);
    check_front();

    drive(0, 1, 4'b0110, 8'h42, 8'h00, 13'h0);
    push("jmp", M_CT | M_A, 0, 0, 0,
         6'b010000, 3'b101, 0, 0);
    check_front();

    drive(0, 0, 4'b0110, 8'h42, 8'h00, 13'h0);
    push("jmp_h0", M_CT | M_A, 0, 0, 0,
         6'b000000, 3'b000, 0, 0);
    check_front();

    drive(0, 1, 4'b1110, 8'h42, 8'h00, 13'h0);
    push("cfg", M_CT | M_A, 0, 0, 0,
         6'b000000, 3'b000, 0, 0);
    check_front();

    drive(0, 1, 4'b1001, 8'h42, 8'h00, 13'h0);
    push("add_h1", M_CT | M_A, 0, 0, 0,
         6'b000000, 3'b000, 0, 0);
    check_front();

    drive(0, 1, 4'b0001, 8'h11, 8'h00, 13'h1FFF);
    @(posedge clk);
    drive(0, 1, 4'b0001, 8'h22, 8'h00, 13'h0000);
    @(posedge clk);
    drive(0, 0, 4'b1111, 8'h00, 8'h00, 13'h1FFF);
    push("hi_addr", M_D, 0, 0, 0, 0, 0, 0, 8'h11);
    check_front();
    drive(0, 0, 4'b1111, 8'h00, 8'h00, 13'h0000);
    push("lo_addr", M_D, 0, 0, 0, 0, 0, 0, 8'h22);
    check_front();

    drive(0, 0, 4'b1111, 8'h00, 8'h00, 13'h1ABC);
    push("keep", M_D, 0, 0, 0, 0, 0, 0, 8'h77);
    check_front();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
